// File: rtl/regfile_wr_arbiter_if.sv
// Register-file writeback bus: two push ports (A = ALU, B = load) and the write port.
// Latency: none, wiring only.
// Backpressure: a_ready/b_ready are driven by the arbiter from FIFO occupancy.
interface regfile_wr_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          a_valid;
    logic          a_ready;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;
    logic          b_valid;
    logic          b_ready;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;
    logic [AW-1:0] write_reg;
    logic [DW-1:0] write_data;
    logic          RegWrite;
    logic [31:0]   pending_mask;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, write_reg, write_data, RegWrite, pending_mask
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, write_reg, write_data, RegWrite, pending_mask
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Generic FIFO that also exposes every slot and its occupancy for hazard tracking.
// Latency: push visible at head one cycle later.
// Backpressure: full asserted at DEPTH entries; caller must not push when full or pop when empty.
module wr_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     push_dat,
    input  logic             pop,
    output logic [W-1:0]     head_dat,
    output logic             empty,
    output logic             full,
    output logic [W-1:0]     ent_dat [DEPTH],
    output logic [DEPTH-1:0] ent_vld
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic [PW-1:0] off;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));
    assign head_dat = mem[rd_ptr];
    assign ent_dat  = mem;

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        ent_vld = '0;
        off     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off        = PW'(i) - rd_ptr;
            ent_vld[i] = ({1'b0, off} < cnt);
        end
    end
endmodule

// Shares the register-file write port between ALU (A) and load (B) writebacks.
// Latency: push at edge N, RegWrite high N+1..N+2, register file writes at edge N+2.
// Backpressure: a_ready/b_ready drop when that source's FIFO is full.
module regfile_wr_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int AW         = 5,
    parameter int DW         = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wr_arbiter_if.slave  bus
);
    localparam int EW = AW + DW;

    logic          a_push, b_push;
    logic          a_pop, b_pop;
    logic          a_empty, b_empty;
    logic          a_full, b_full;
    logic [EW-1:0] a_head, b_head;
    logic [EW-1:0] a_ent [FIFO_DEPTH];
    logic [EW-1:0] b_ent [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] a_ent_vld, b_ent_vld;

    logic          last_grant_b;
    logic [EW-1:0] pop_dat;
    logic          popped;

    logic          reg_write_q;
    logic [AW-1:0] write_reg_q;
    logic [DW-1:0] write_data_q;
    logic [31:0]   mask;

    assign bus.a_ready = !a_full;
    assign bus.b_ready = !b_full;
    assign a_push      = bus.a_valid && !a_full;
    assign b_push      = bus.b_valid && !b_full;

    wr_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (a_push),
        .push_dat ({bus.a_addr, bus.a_data}),
        .pop      (a_pop),
        .head_dat (a_head),
        .empty    (a_empty),
        .full     (a_full),
        .ent_dat  (a_ent),
        .ent_vld  (a_ent_vld)
    );

    wr_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (b_push),
        .push_dat ({bus.b_addr, bus.b_data}),
        .pop      (b_pop),
        .head_dat (b_head),
        .empty    (b_empty),
        .full     (b_full),
        .ent_dat  (b_ent),
        .ent_vld  (b_ent_vld)
    );

    // On a tie the source that did not win the last contested grant goes first.
    assign a_pop   = !a_empty && (b_empty || last_grant_b);
    assign b_pop   = !b_empty && (a_empty || !last_grant_b);
    assign popped  = a_pop || b_pop;
    assign pop_dat = a_pop ? a_head : b_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_b <= 1'b1;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            if (!a_empty && !b_empty) last_grant_b <= b_pop;
            reg_write_q <= popped && (pop_dat[EW-1:DW] != '0);
            if (popped && (pop_dat[EW-1:DW] != '0)) begin
                write_reg_q  <= pop_dat[EW-1:DW];
                write_data_q <= pop_dat[DW-1:0];
            end
        end
    end

    assign bus.RegWrite   = reg_write_q;
    assign bus.write_reg  = write_reg_q;
    assign bus.write_data = write_data_q;

    always_comb begin
        mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (a_ent_vld[i]) mask = mask | (32'd1 << a_ent[i][EW-1:DW]);
            if (b_ent_vld[i]) mask = mask | (32'd1 << b_ent[i][EW-1:DW]);
        end
        if (reg_write_q) mask = mask | (32'd1 << write_reg_q);
        mask[0] = 1'b0;
    end

    assign bus.pending_mask = mask;
endmodule
